// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: write-only AHB-Lite master that shares the VGA slave
// between a console stream (requester 0) and an image/fill engine
// (requester 1). Round-robin arbitration, single NONSEQ word writes,
// wait-state support, and sticky DLS / wait-timeout error flags.
module vga_write_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter bit          STOP_ON_ERR = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic              DLS_ERROR,
    input  logic              err_clr,
    output logic [1:0]        err_code,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [15:0] TO_LIM        = 16'(TIMEOUT);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;          // 0: requester 0 wins a tie
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              hsel_q, hsel_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [1:0]        err_q, err_d;
    logic [15:0]       tcnt_q, tcnt_d;

    logic eligible;
    logic winner;
    logic set_to;

    // Next-state logic: arbitration in IDLE, AHB phase sequencing, timeout and error flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        hsel_d   = hsel_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        tcnt_d   = tcnt_q;
        set_to   = 1'b0;

        eligible = (req0_valid || req1_valid) && !(STOP_ON_ERR && (err_q != 2'b00));
        winner   = (req0_valid && req1_valid) ? rr_q : req1_valid;

        case (state_q)
            S_IDLE: begin
                if (eligible) begin
                    grant_d  = winner ? 2'b10 : 2'b01;
                    haddr_d  = winner ? req1_addr : req0_addr;
                    hwdata_d = winner ? req1_data : req0_data;
                    rr_d     = ~winner;
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    hwrite_d = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADYOUT) begin
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                    hwrite_d = 1'b0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADYOUT) begin
                    grant_d = 2'b00;
                    tcnt_d  = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    // Flag when this wait cycle brings the count up to the limit; keep waiting.
                    set_to = (tcnt_q >= TO_LIM - 16'd1);
                    if (tcnt_q < TO_LIM) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A set condition in the same cycle as err_clr wins over the clear.
        err_d = (err_clr ? 2'b00 : err_q) | {set_to, DLS_ERROR};
    end

    // State and output registers; reset abandons any in-flight transfer.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            rr_q     <= 1'b0;
            grant_q  <= 2'b00;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hsel_q   <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            err_q    <= 2'b00;
            tcnt_q   <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            hsel_q   <= hsel_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign HSEL       = hsel_q;
    assign HADDR      = haddr_q;
    assign HTRANS     = htrans_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = 3'b010;
    assign HWDATA     = hwdata_q;
    assign HREADY     = HREADYOUT;
    assign err_code   = err_q;
    assign grant      = grant_q;
    assign busy       = (state_q != S_IDLE);
    assign req0_ready = (state_q == S_DATA) && HREADYOUT && grant_q[0];
    assign req1_ready = (state_q == S_DATA) && HREADYOUT && grant_q[1];

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed vectors, completions checked by a
// scoreboard monitor, cycle-level details checked inline. A second instance
// with TIMEOUT=4 exercises the wait-state timeout flag.
module tb_vga_write_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req0_valid, req1_valid, t_req0_valid;
    logic [31:0] req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        HREADYOUT, DLS_ERROR, err_clr;

    logic        req0_ready, req1_ready, HSEL, HWRITE, HREADY, busy;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS, err_code, grant;
    logic [2:0]  HSIZE;

    logic        t_req0_ready, t_req1_ready, t_hsel, t_hwrite, t_hready, t_busy;
    logic [31:0] t_haddr, t_hwdata;
    logic [1:0]  t_htrans, t_err, t_grant;
    logic [2:0]  t_hsize;

    always #5 HCLK = ~HCLK;

    vga_write_arbiter dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .DLS_ERROR(DLS_ERROR),
        .err_clr(err_clr), .err_code(err_code), .grant(grant), .busy(busy)
    );

    vga_write_arbiter #(.TIMEOUT(4)) dut_t (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0_valid(t_req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(t_req0_ready),
        .req1_valid(1'b0), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(t_req1_ready),
        .HSEL(t_hsel), .HADDR(t_haddr), .HTRANS(t_htrans), .HWRITE(t_hwrite), .HSIZE(t_hsize),
        .HWDATA(t_hwdata), .HREADY(t_hready), .HREADYOUT(HREADYOUT), .DLS_ERROR(DLS_ERROR),
        .err_clr(err_clr), .err_code(t_err), .grant(t_grant), .busy(t_busy)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_t_q[$];
    exp_t e_m, e_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Scoreboard monitor for the main instance: every ready pulse pops one expected write.
    always @(negedge HCLK) begin
        if (req0_ready || req1_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
            end else begin
                e_m = exp_q.pop_front();
                check("sb_ready_id", {req1_ready, req0_ready}, e_m.id);
                check("sb_grant",    grant,  e_m.id);
                check("sb_haddr",    HADDR,  e_m.addr);
                check("sb_hwdata",   HWDATA, e_m.data);
            end
        end
    end

    // Scoreboard monitor for the TIMEOUT=4 instance.
    always @(negedge HCLK) begin
        if (t_req0_ready || t_req1_ready) begin
            if (exp_t_q.size() == 0) begin
                check("t_unexpected_ready", {62'd0, t_req1_ready, t_req0_ready}, 64'd0);
            end else begin
                e_t = exp_t_q.pop_front();
                check("t_sb_ready_id", {t_req1_ready, t_req0_ready}, e_t.id);
                check("t_sb_grant",    t_grant,  e_t.id);
                check("t_sb_haddr",    t_haddr,  e_t.addr);
                check("t_sb_hwdata",   t_hwdata, e_t.data);
            end
        end
    end

    initial begin
        HRESET = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; t_req0_valid = 1'b0;
        req0_addr = '0; req0_data = '0; req1_addr = '0; req1_data = '0;
        HREADYOUT = 1'b1; DLS_ERROR = 1'b0; err_clr = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_hsel", HSEL, 0);     check("rst_htrans", HTRANS, 0);
        check("rst_hwrite", HWRITE, 0); check("rst_haddr", HADDR, 0);
        check("rst_hwdata", HWDATA, 0); check("rst_hsize", HSIZE, 3'b010);
        check("rst_grant", grant, 0);   check("rst_err", err_code, 0);
        check("rst_busy", busy, 0);     check("rst_ready0", req0_ready, 0);
        HRESET = 1'b0;
        tick();

        // Single write from requester 0, zero wait states
        req0_valid = 1'b1; req0_addr = 32'h5000_0000; req0_data = 32'h41;
        exp_q.push_back('{2'b01, 32'h5000_0000, 32'h41});
        tick();
        check("t1_addr_hsel", HSEL, 1);       check("t1_addr_htrans", HTRANS, 2'b10);
        check("t1_addr_hwrite", HWRITE, 1);   check("t1_addr_haddr", HADDR, 32'h5000_0000);
        check("t1_addr_grant", grant, 2'b01); check("t1_addr_busy", busy, 1);
        check("t1_addr_ready0", req0_ready, 0);
        tick();
        check("t1_data_hsel", HSEL, 0);       check("t1_data_htrans", HTRANS, 2'b00);
        check("t1_data_hwrite", HWRITE, 0);   check("t1_data_hwdata", HWDATA, 32'h41);
        check("t1_data_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("t1_idle_grant", grant, 0);     check("t1_idle_busy", busy, 0);
        check("t1_idle_ready0", req0_ready, 0);

        // Round robin with both requesters held valid (pointer reset to 0)
        HRESET = 1'b1; tick(); HRESET = 1'b0;
        req0_addr = 32'h5000_0010; req0_data = 32'h100;
        req1_addr = 32'h5000_0020; req1_data = 32'h200;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_q.push_back('{2'b01, 32'h5000_0010, 32'h100});
        exp_q.push_back('{2'b10, 32'h5000_0020, 32'h200});
        exp_q.push_back('{2'b01, 32'h5000_0014, 32'h101});
        exp_q.push_back('{2'b10, 32'h5000_0024, 32'h201});
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_grant", grant, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            check("t2_data_ready", {req1_ready, req0_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            if (k == 0) begin req0_addr = 32'h5000_0014; req0_data = 32'h101; end
            if (k == 1) begin req1_addr = 32'h5000_0024; req1_data = 32'h201; end
            if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        check("t2_end_grant", grant, 0);
        check("t2_end_busy", busy, 0);

        // Three wait states in the data phase
        req1_valid = 1'b1; req1_addr = 32'h5000_0100; req1_data = 32'hDEAD_BEEF;
        exp_q.push_back('{2'b10, 32'h5000_0100, 32'hDEAD_BEEF});
        tick();
        check("t3_grant", grant, 2'b10);
        tick();
        HREADYOUT = 1'b0; #1;
        check("t3_wait_ready1", req1_ready, 0);
        check("t3_hready_copy", HREADY, 0);
        check("t3_wait_hwdata", HWDATA, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t3_wait_ready1", req1_ready, 0);
            check("t3_wait_hwdata", HWDATA, 32'hDEAD_BEEF);
        end
        tick();
        HREADYOUT = 1'b1; #1;
        check("t3_ready1_4th", req1_ready, 1);
        check("t3_no_timeout", err_code, 0);
        tick();
        req1_valid = 1'b0;
        check("t3_idle_busy", busy, 0);
        check("t3_idle_err", err_code, 0);

        // Timeout flag on the TIMEOUT=4 instance, then grant blocked until err_clr
        t_req0_valid = 1'b1; req0_addr = 32'h5000_0200; req0_data = 32'h55;
        exp_t_q.push_back('{2'b01, 32'h5000_0200, 32'h55});
        tick();
        check("t4_grant", t_grant, 2'b01);
        tick();
        HREADYOUT = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t4_err", t_err, (k >= 4) ? 2'b10 : 2'b00);
            check("t4_wait_ready0", t_req0_ready, 0);
        end
        HREADYOUT = 1'b1; #1;
        check("t4_completes", t_req0_ready, 1);
        tick();
        req0_addr = 32'h5000_0204; req0_data = 32'h56;
        exp_t_q.push_back('{2'b01, 32'h5000_0204, 32'h56});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_blocked_grant", t_grant, 0);
            check("t4_blocked_busy", t_busy, 0);
            check("t4_err_sticky", t_err, 2'b10);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4_err_cleared", t_err, 0);
        check("t4_still_idle", t_grant, 0);
        tick();
        check("t4_regrant", t_grant, 2'b01);
        check("t4_regrant_htrans", t_htrans, 2'b10);
        tick();
        tick();
        t_req0_valid = 1'b0;
        check("t4_idle_busy", t_busy, 0);

        // DLS error with a simultaneous clear: set wins; clear alone then unblocks
        DLS_ERROR = 1'b1; err_clr = 1'b1;
        tick();
        DLS_ERROR = 1'b0;
        check("t5_set_wins", err_code, 2'b01);
        req0_valid = 1'b1; req0_addr = 32'h5000_0300; req0_data = 32'h77;
        exp_q.push_back('{2'b01, 32'h5000_0300, 32'h77});
        tick();
        err_clr = 1'b0;
        check("t5_cleared", err_code, 0);
        check("t5_blocked", grant, 0);
        tick();
        check("t5_grant", grant, 2'b01);
        check("t5_htrans", HTRANS, 2'b10);
        tick();
        tick();

        // Reset during ADDR: immediate reset values, no ready, reissue with pointer at 0
        req0_addr = 32'h5000_0400; req0_data = 32'h88;
        req1_valid = 1'b1; req1_addr = 32'h5000_0500; req1_data = 32'h99;
        tick();
        check("t6_pre_grant", grant, 2'b10);
        HRESET = 1'b1; #1;
        check("t6_rst_hsel", HSEL, 0);     check("t6_rst_htrans", HTRANS, 0);
        check("t6_rst_hwrite", HWRITE, 0); check("t6_rst_haddr", HADDR, 0);
        check("t6_rst_hwdata", HWDATA, 0); check("t6_rst_grant", grant, 0);
        check("t6_rst_busy", busy, 0);     check("t6_rst_ready", {req1_ready, req0_ready}, 0);
        tick();
        HRESET = 1'b0;
        exp_q.push_back('{2'b01, 32'h5000_0400, 32'h88});
        exp_q.push_back('{2'b10, 32'h5000_0500, 32'h99});
        tick();
        check("t6_reissue_grant", grant, 2'b01);
        check("t6_reissue_haddr", HADDR, 32'h5000_0400);
        tick();
        tick();
        req0_valid = 1'b0;
        tick();
        check("t6_req1_grant", grant, 2'b10);
        check("t6_req1_haddr", HADDR, 32'h5000_0500);
        tick();
        tick();
        req1_valid = 1'b0;
        check("t6_idle_busy", busy, 0);
        tick();

        check("sb_drained", exp_q.size(), 0);
        check("t_sb_drained", exp_t_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- AHB-Lite write-only master that shares the VGA peripheral (AHBVGADLS slave) between two requesters: requester 0 is the console/CPU-side stream and requester 1 is the image/fill engine.
- Arbitrates round-robin and sequences single NONSEQ word writes, honouring slave wait states (HREADYOUT).
- Monitors the slave's DLS_ERROR plus a wait-state timeout, and reports both as sticky error flags.

Parameters:
- ADDR_W, 32, width of requester and HADDR addresses
- DATA_W, 32, width of requester and HWDATA data
- STOP_ON_ERR, 1, 1: no new grants while any sticky error is set
- TIMEOUT, 255, max consecutive HREADYOUT=0 cycles in the data phase before the timeout flag sets (range 1..65535)

Ports:
- HCLK  in  1  clock
- HRESET  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_W  requester 0 target address
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  1-cycle pulse: requester 0 write completed
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0
- HSEL  out  1  slave select (address phase)
- HADDR  out  ADDR_W  AHB address
- HTRANS  out  2  2'b10 NONSEQ or 2'b00 IDLE
- HWRITE  out  1  write strobe
- HSIZE  out  3  fixed 3'b010 (word)
- HWDATA  out  DATA_W  AHB write data (data phase)
- HREADY  out  1  to slave; combinational copy of HREADYOUT
- HREADYOUT  in  1  slave ready
- DLS_ERROR  in  1  slave lockstep error
- err_clr  in  1  clears sticky errors
- err_code  out  2  bit0 DLS error seen; bit1 timeout seen
- grant  out  2  one-hot owner of the current transfer, 2'b00 when idle
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, HRESET=1) forces:
  - state IDLE, round-robin pointer at requester 0
  - HSEL=0, HADDR=0, HTRANS=00, HWRITE=0, HWDATA=0, HSIZE=010
  - reqN_ready=0, grant=00, err_code=00, busy=0, timeout counter 0
- Reset asserted mid-transfer abandons the transfer with no ready pulse; the requester must re-present it.
- All outputs except HREADY and reqN_ready are registered.
- FSM has 3 states: IDLE, ADDR, DATA.
- IDLE:
  - Arbitration is eligible when any valid is high and not (STOP_ON_ERR && err_code!=0).
  - If both requesters are valid, the pointer side wins; otherwise the single valid requester wins.
  - The winner's addr/data are latched, grant is set, and the FSM goes to ADDR.
  - After each grant the pointer moves to the non-winner.
- ADDR: HSEL=1, HTRANS=10, HWRITE=1, HADDR=latched address.
  - Advance to DATA when HREADYOUT=1; otherwise hold ADDR with all signals stable.
- DATA: HSEL=0, HTRANS=00, HWRITE=0, HWDATA=latched data.
  - reqN_ready = (state==DATA) && HREADYOUT && grant[N], combinational.
  - On HREADYOUT=1, go to IDLE and clear grant. HWDATA holds its value until the next grant.
- Latency, zero wait states: valid sampled in IDLE at cycle N, ADDR at N+1, DATA with ready pulse at N+2. Maximum throughput is one write per 3 cycles.
- Each wait state (HREADYOUT=0) adds one cycle.
- Requester rule: valid, addr and data stay stable from assertion through the ready cycle. Valid may not drop before ready. Valid is sampled again only in IDLE, so no double-issue occurs.
- Timeout:
  - A counter increments on each DATA cycle with HREADYOUT=0 and resets on leaving DATA.
  - When the count reaches TIMEOUT, err_code[1] sets.
  - The transfer keeps waiting; the AHB data phase is never abandoned.
  - The counter saturates.
- DLS: err_code[0] sets on any cycle with DLS_ERROR=1, in any state.
- err_clr clears both bits next edge. If a set condition and err_clr occur in the same cycle, the set wins.
- STOP_ON_ERR=1 blocks only new grants; an in-flight transfer completes normally.
- Single requester streaming: back-to-back grants to the same requester are legal when the other requester is idle.

Test Plan:
- Reset, then req0_valid with addr 0x5000_0000, data 0x41: ADDR at +1 with HTRANS=10/HWRITE=1; DATA at +2 with HWDATA=0x41 and req0_ready 1-cycle pulse; grant=01 then 00.
- Both requesters held valid for 4 transfers, no waits: grant order 01,10,01,10; each ready pulse once per transfer; 12 cycles total.
- HREADYOUT=0 for 3 cycles in DATA: HWDATA stable; req1_ready asserts only on the 4th DATA cycle; no timeout with TIMEOUT=255.
- TIMEOUT=4, HREADYOUT held low for 6 cycles: err_code=10 after the 4th low cycle; transfer still completes; next grant is blocked until err_clr pulses.
- DLS_ERROR pulse in IDLE with err_clr high the same cycle: err_code=01 remains. err_clr alone next cycle clears it to 00. A pending req0 is then granted the following cycle.
- HRESET asserted during ADDR: outputs immediately reset values; no ready pulse. After release, the still-valid request is re-issued from IDLE with pointer at requester 0.
